rsa_job_ctrl: RTL and testbench

Sequencer that owns the rsa_unit instance and runs one modular-exponentiation job per start request.
- Snapshots the P/E/M/Const operand registers into shadow registers.
- Holds rsa_unit operands stable, drives its enable, waits for end-of-conversion, and captures the result.
- Guards each job with a timeout; supports abort.
- Publishes an 8-bit status byte for register address 0.
- Sits between the SPI register file and rsa_unit; replaces the direct register-to-rsa_unit wiring.

---
 rtl/rsa_ctrl_pkg.sv | 17 +
 rtl/rsa_timeout_cnt.sv | 28 ++
 rtl/rsa_job_ctrl.sv | 158 +++++++++++++++
 tb/tb_rsa_job_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rsa_ctrl_pkg.sv
// Shared definitions for the rsa_unit job sequencer: FSM states and the
// status byte bit positions also used by the register map.
package rsa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_BUSY = 1;
  localparam int unsigned ST_TOUT = 2;
  localparam int unsigned ST_OVR  = 3;
  localparam int unsigned ST_ABT  = 4;

endpackage

// File: rtl/rsa_timeout_cnt.sv
// Job watchdog: cleared before each run, counts enabled cycles and
// saturates at TIMEOUT_CYC-1, where it flags expiry.
module rsa_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TMR_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/rsa_job_ctrl.sv
// Runs one modular-exponentiation job on rsa_unit per accepted start:
// shadows operands, sequences enable, guards with a timeout, reports status.
module rsa_job_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TMR_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] p_i,
  input  logic [DATA_W-1:0] e_i,
  input  logic [DATA_W-1:0] m_i,
  input  logic [DATA_W-1:0] const_i,
  output logic              rsa_en,
  output logic [DATA_W-1:0] rsa_p,
  output logic [DATA_W-1:0] rsa_e,
  output logic [DATA_W-1:0] rsa_m,
  output logic [DATA_W-1:0] rsa_const,
  input  logic              rsa_eoc,
  input  logic [DATA_W-1:0] rsa_c,
  output logic [DATA_W-1:0] result,
  output logic              result_vld,
  output logic              busy,
  output logic [7:0]        status
);

  state_t r_state;
  state_t w_nxt;

  logic r_rsa_en, r_vld, r_done, r_tout, r_ovr, r_abt;
  logic [DATA_W-1:0] r_p, r_e, r_m, r_const, r_result;

  logic w_accept, w_fin_done, w_fin_tout, w_fin_abt, w_ovr;
  logic w_tmr_clr, w_tmr_en, w_en_nxt, w_expired;

  rsa_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TMR_W      (TMR_W)
  ) u_tmr (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // Priority in RUN: abort over eoc over timeout; start outside IDLE only flags overrun.
  always_comb begin
    w_nxt      = r_state;
    w_accept   = 1'b0;
    w_fin_done = 1'b0;
    w_fin_tout = 1'b0;
    w_fin_abt  = 1'b0;
    w_ovr      = 1'b0;
    w_tmr_clr  = 1'b0;
    w_tmr_en   = 1'b0;
    w_en_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_nxt    = LOAD;
        end
      end
      LOAD: begin
        w_ovr = start;
        if (abort) begin
          w_fin_abt = 1'b1;
          w_nxt     = IDLE;
        end else begin
          w_tmr_clr = 1'b1;
          w_en_nxt  = 1'b1;
          w_nxt     = RUN;
        end
      end
      RUN: begin
        w_ovr = start;
        if (abort) begin
          w_fin_abt = 1'b1;
          w_nxt     = IDLE;
        end else if (rsa_eoc) begin
          w_fin_done = 1'b1;
          w_nxt      = IDLE;
        end else if (w_expired) begin
          w_fin_tout = 1'b1;
          w_nxt      = IDLE;
        end else begin
          w_tmr_en = 1'b1;
          w_en_nxt = 1'b1;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsa_en <= 1'b0;
      r_vld    <= 1'b0;
      r_done   <= 1'b0;
      r_tout   <= 1'b0;
      r_ovr    <= 1'b0;
      r_abt    <= 1'b0;
      r_p      <= '0;
      r_e      <= '0;
      r_m      <= '0;
      r_const  <= '0;
      r_result <= '0;
    end else begin
      r_rsa_en <= w_en_nxt;
      r_vld    <= w_fin_done;
      if (w_accept) begin
        r_p     <= p_i;
        r_e     <= e_i;
        r_m     <= m_i;
        r_const <= const_i;
        r_done  <= 1'b0;
        r_tout  <= 1'b0;
        r_ovr   <= 1'b0;
        r_abt   <= 1'b0;
      end else begin
        if (w_fin_done) r_done <= 1'b1;
        if (w_fin_tout) r_tout <= 1'b1;
        if (w_fin_abt)  r_abt  <= 1'b1;
        if (w_ovr)      r_ovr  <= 1'b1;
      end
      if (w_fin_done) r_result <= rsa_c;
    end
  end

  always_comb begin
    status          = '0;
    status[ST_DONE] = r_done;
    status[ST_BUSY] = busy;
    status[ST_TOUT] = r_tout;
    status[ST_OVR]  = r_ovr;
    status[ST_ABT]  = r_abt;
  end

  assign busy       = (r_state != IDLE);
  assign rsa_en     = r_rsa_en;
  assign rsa_p      = r_p;
  assign rsa_e      = r_e;
  assign rsa_m      = r_m;
  assign rsa_const  = r_const;
  assign result     = r_result;
  assign result_vld = r_vld;

endmodule

// File: tb/tb_rsa_job_ctrl.sv
// Scoreboard bench for rsa_job_ctrl with an inline rsa_unit stub and a
// job-level outcome model (abort > eoc > timeout, overrun on start while busy).
module tb_rsa_job_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst, start, abort, rsa_eoc;
  logic [7:0] p_i, e_i, m_i, const_i, rsa_c;
  logic       rsa_en, result_vld, busy;
  logic [7:0] rsa_p, rsa_e, rsa_m, rsa_const, result, status;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] st;
    logic [7:0] res;
  } job_t;

  job_t       q_job[$];
  logic [7:0] q_res[$];
  logic [7:0] exp_result  = '0;
  logic [7:0] last_status = '0;

  rsa_job_ctrl #(.DATA_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .p_i(p_i), .e_i(e_i), .m_i(m_i), .const_i(const_i),
    .rsa_en(rsa_en), .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m),
    .rsa_const(rsa_const), .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
    .result(result), .result_vld(result_vld), .busy(busy), .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations when the DUT presents a result or finishes a job.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (result_vld === 1'b1) begin
      if (q_res.size() == 0) check("unexpected_result_vld", 32'(result_vld), 32'd0);
      else check("result_on_vld", 32'(result), 32'(q_res.pop_front()));
    end
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (q_job.size() == 0) begin
        check("unexpected_job_end", 32'(status), 32'hff);
      end else begin
        job_t j;
        j = q_job.pop_front();
        check("job_status", 32'(status), 32'(j.st));
        check("job_result", 32'(result), 32'(j.res));
        check("rsa_en_low_at_end", 32'(rsa_en), 32'd0);
      end
    end
    prev_busy = busy;
  end

  // Indices: 0 = LOAD cycle, i>=1 = RUN cycle i-1. -1 means "not applied".
  // ei: eoc index (1..TO), ai: abort index, oi: extra start index, ri: reset index.
  task automatic run_job(input int ai, input int ei, input int oi, input int ri,
                         input logic [7:0] p, input logic [7:0] e,
                         input logic [7:0] m, input logic [7:0] k,
                         input logic [7:0] c);
    int f;
    bit abt, dn, tout, ovr;
    job_t j;
    f = TO;
    if (ei >= 1 && ei <= f) f = ei;
    if (ai >= 0 && ai <= f) f = ai;
    if (ri >= 0) begin
      exp_result = '0;
      j.st = 8'h00; j.res = 8'h00;
    end else begin
      abt  = (ai >= 0 && ai == f);
      dn   = !abt && (ei >= 1 && ei == f);
      tout = !abt && !dn;
      ovr  = (oi >= 0 && oi <= f);
      if (dn) begin
        exp_result = c;
        q_res.push_back(c);
      end
      j.st  = {3'b000, abt, ovr, tout, 1'b0, dn};
      j.res = exp_result;
    end
    q_job.push_back(j);
    last_status = j.st;

    start = 1'b1; p_i = p; e_i = e; m_i = m; const_i = k;
    @(posedge clk); #1;
    for (int i = 0; i <= f; i++) begin
      check($sformatf("rsa_en_idx%0d", i), 32'(rsa_en), (i >= 1) ? 32'd1 : 32'd0);
      check("shadow_operands", {rsa_p, rsa_e, rsa_m, rsa_const}, {p, e, m, k});
      p_i = 8'($urandom); e_i = 8'($urandom); m_i = 8'($urandom); const_i = 8'($urandom);
      start   = (i == oi);
      abort   = (i == ai);
      rsa_eoc = (i == ei) && (i >= 1);
      rsa_c   = (i == ei) ? c : 8'($urandom);
      rst     = (i == ri);
      @(posedge clk); #1;
      if (i == ri) break;
    end
    start = 1'b0; abort = 1'b0; rsa_eoc = 1'b0; rst = 1'b0;
    check("busy_after_job", 32'(busy), 32'd0);
    check("rsa_en_after_job", 32'(rsa_en), 32'd0);
    if (ri >= 0)
      check("shadows_after_reset", {rsa_p, rsa_e, rsa_m, rsa_const}, 32'd0);
    // Idle gap: spurious eoc/abort must change nothing.
    for (int g = 0; g < 3; g++) begin
      rsa_eoc = $urandom_range(0, 1) == 1;
      abort   = $urandom_range(0, 1) == 1;
      rsa_c   = 8'($urandom);
      @(posedge clk); #1;
    end
    rsa_eoc = 1'b0; abort = 1'b0;
    check("idle_status_stable", 32'(status), 32'(last_status));
    check("idle_result_stable", 32'(result), 32'(exp_result));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rsa_eoc = 1'b0;
    p_i = '0; e_i = '0; m_i = '0; const_i = '0; rsa_c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsa_en", 32'(rsa_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_result_vld", 32'(result_vld), 32'd0);
    check("rst_shadows", {rsa_p, rsa_e, rsa_m, rsa_const}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(-1, 11, -1, -1, 8'd33, 8'd3, 8'd5, 8'd0, 8'd26); // basic
    run_job(-1, -1, -1, -1, 8'd7, 8'd9, 8'd11, 8'd1, 8'd99); // timeout
    run_job( 6,  6, -1, -1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd77);  // abort beats eoc
    run_job(-1,  5, -1, -1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd41);  // normal after abort
    run_job(-1,  9,  4, -1, 8'd33, 8'd3, 8'd5, 8'd0, 8'd55); // overrun mid-RUN
    run_job(-1, TO, -1, -1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd88);  // eoc/timeout tie
    run_job( 0, -1, -1, -1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd12);  // abort in LOAD
    run_job(-1,  7,  7, -1, 8'd5, 8'd6, 8'd7, 8'd8, 8'd34);  // start at completion
    run_job(-1, -1,  0, -1, 8'd5, 8'd6, 8'd7, 8'd8, 8'd34);  // start in LOAD, timeout

    for (int n = 0; n < 30; n++) begin
      int a, e, o;
      e = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, TO));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO)) : -1;
      o = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TO)) : -1;
      run_job(a, e, o, -1, 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));
    end

    run_job(-1, 12, -1, 5, 8'd33, 8'd3, 8'd5, 8'd7, 8'd66);  // reset mid-RUN
    run_job(-1,  3, -1, -1, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50);

    repeat (2) @(posedge clk);
    #1;
    check("res_queue_drained", 32'(q_res.size()), 32'd0);
    check("job_queue_drained", 32'(q_job.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
